// File: rtl/mfda_seq_pkg.sv
// Shared types and helpers for the mixer-tree valve sequencer.
// Holds the phase enum, the zero-duration clamp and the default phase timings.
package mfda_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    MIX   = 3'd2,
    DRAIN = 3'd3,
    FLUSH = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [15:0] DEF_FILL_TIME  = 16'd4;
  localparam logic [15:0] DEF_MIX_TIME   = 16'd3;
  localparam logic [15:0] DEF_DRAIN_TIME = 16'd2;

  // A programmed duration of 0 still occupies one cycle.
  function automatic logic [31:0] clamp_dur(input logic [31:0] t);
    return (t == 32'd0) ? 32'd1 : t;
  endfunction

endpackage

// File: rtl/mix_tree_sequencer_if.sv
// Host-side control/status bundle of the mixer-tree sequencer.
// Level-sampled controls, no handshake: start is a one-cycle request, abort is a level.
interface mix_tree_sequencer_if
  import mfda_seq_pkg::*;
#(
  parameter int N_INLETS = 8,
  parameter int LEVELS   = 3,
  parameter int CNT_W    = 16
);
  logic                start;
  logic                abort;
  logic [N_INLETS-1:0] inlet_mask;
  logic [CNT_W-1:0]    fill_time;
  logic [CNT_W-1:0]    mix_time;
  logic [CNT_W-1:0]    drain_time;
  logic [N_INLETS-1:0] inlet_valve;
  logic [LEVELS-1:0]   level_valve;
  logic                out_valve;
  logic                flush_valve;
  logic                busy;
  logic                done;
  logic                aborted;
  logic                cfg_err;
  state_t              dbg_state;

  modport master (
    output start, abort, inlet_mask, fill_time, mix_time, drain_time,
    input  inlet_valve, level_valve, out_valve, flush_valve,
    input  busy, done, aborted, cfg_err, dbg_state
  );

  modport slave (
    input  start, abort, inlet_mask, fill_time, mix_time, drain_time,
    output inlet_valve, level_valve, out_valve, flush_valve,
    output busy, done, aborted, cfg_err, dbg_state
  );
endinterface

// File: rtl/mix_tree_sequencer_phase_timer.sv
// Down-counter timing one sequencer phase: load a value, count to zero, flag expiry.
// Holds at zero once reached so it never wraps past the end of a phase.
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_expire
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = (r_count == '0);
endmodule

// File: rtl/mix_tree_sequencer.sv
// Valve sequencer for a binary mixer tree: fill, level-by-level mix, drain, flush.
// Valve/status outputs are registered from the current phase, so they trail the state by one cycle.
module mix_tree_sequencer
  import mfda_seq_pkg::*;
#(
  parameter int N_INLETS = 8,
  parameter int LEVELS   = 3,
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               rst_n,
  mix_tree_sequencer_if.slave bus
);
  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  state_t              r_state, w_state_nx;
  logic [LW-1:0]       r_level, w_level_nx;
  logic [N_INLETS-1:0] r_mask;
  logic [CNT_W-1:0]    r_mix, r_drain;
  logic                r_abort_run;
  logic                w_load, w_latch, w_set_abort, w_cfg_err_nx, w_expire;
  logic [CNT_W-1:0]    w_load_val;

  logic [N_INLETS-1:0] r_inlet_valve;
  logic [LEVELS-1:0]   r_level_valve;
  logic                r_out_valve, r_flush_valve, r_busy, r_done, r_aborted, r_cfg_err;

  function automatic logic [CNT_W-1:0] load_of(input logic [CNT_W-1:0] t);
    return CNT_W'(clamp_dur(32'(t)) - 32'd1);
  endfunction

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_value  (w_load_val),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nx   = r_state;
    w_level_nx   = r_level;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_latch      = 1'b0;
    w_set_abort  = 1'b0;
    w_cfg_err_nx = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (|bus.inlet_mask) begin
            w_latch    = 1'b1;
            w_state_nx = FILL;
            w_load     = 1'b1;
            w_load_val = load_of(bus.fill_time);
          end else begin
            w_cfg_err_nx = 1'b1;
          end
        end
      end
      FILL, MIX, DRAIN: begin
        // Abort bypasses the remaining phases with a fresh flush timer.
        if (bus.abort) begin
          w_set_abort = 1'b1;
          w_state_nx  = FLUSH;
          w_load      = 1'b1;
          w_load_val  = load_of(r_drain);
        end else if (w_expire) begin
          w_load = 1'b1;
          if (r_state == FILL) begin
            w_state_nx = MIX;
            w_level_nx = '0;
            w_load_val = load_of(r_mix);
          end else if (r_state == MIX && r_level != LW'(LEVELS - 1)) begin
            w_level_nx = r_level + 1'b1;
            w_load_val = load_of(r_mix);
          end else begin
            w_state_nx = (r_state == MIX) ? DRAIN : FLUSH;
            w_load_val = load_of(r_drain);
          end
        end
      end
      FLUSH: begin
        if (w_expire) w_state_nx = DONE;
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_level     <= '0;
      r_mask      <= '0;
      r_mix       <= '0;
      r_drain     <= '0;
      r_abort_run <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_level <= w_level_nx;
      if (w_latch) begin
        r_mask      <= bus.inlet_mask;
        r_mix       <= bus.mix_time;
        r_drain     <= bus.drain_time;
        r_abort_run <= 1'b0;
      end else if (w_set_abort) begin
        r_abort_run <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inlet_valve <= '0;
      r_level_valve <= '0;
      r_out_valve   <= 1'b0;
      r_flush_valve <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_inlet_valve <= (r_state == FILL) ? r_mask : '0;
      r_level_valve <= (r_state == MIX) ? (LEVELS'(1) << r_level) : '0;
      r_out_valve   <= (r_state == DRAIN) || (r_state == FLUSH);
      r_flush_valve <= (r_state == FLUSH);
      r_busy        <= (r_state != IDLE);
      r_done        <= (r_state == DONE);
      r_aborted     <= (r_state == DONE) && r_abort_run;
      r_cfg_err     <= w_cfg_err_nx;
    end
  end

  assign bus.inlet_valve = r_inlet_valve;
  assign bus.level_valve = r_level_valve;
  assign bus.out_valve   = r_out_valve;
  assign bus.flush_valve = r_flush_valve;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.aborted     = r_aborted;
  assign bus.cfg_err     = r_cfg_err;
  assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_mix_tree_sequencer.sv
// Directed bench for mix_tree_sequencer: nominal, zero-time, bad-config, abort,
// start-while-busy and asynchronous-reset runs with hand-computed valve vectors.
module tb_mix_tree_sequencer;
  import mfda_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mix_tree_sequencer_if #(.N_INLETS(8), .LEVELS(3), .CNT_W(16)) bus ();

  mix_tree_sequencer #(.N_INLETS(8), .LEVELS(3), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // {inlet[7:0], level[2:0], out, flush, busy, done, aborted, cfg_err}
  logic [16:0] obs;
  assign obs = {bus.inlet_valve, bus.level_valve, bus.out_valve, bus.flush_valve,
                bus.busy, bus.done, bus.aborted, bus.cfg_err};

  function automatic logic [16:0] ev(input logic [7:0] inl, input logic [2:0] lv,
                                     input logic o, input logic f, input logic b,
                                     input logic d, input logic a, input logic c);
    return {inl, lv, o, f, b, d, a, c};
  endfunction

  task automatic sample(input string tag, input logic [16:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [16:0] exp);
    @(negedge clk);
    sample(tag, exp);
  endtask

  task automatic phase(input string tag, input logic [16:0] exp, input int n);
    for (int i = 0; i < n; i++) chk(tag, exp);
  endtask

  task automatic drive_start(input logic [7:0] m, input logic [15:0] f,
                             input logic [15:0] mx, input logic [15:0] d);
    bus.start      = 1'b1;
    bus.inlet_mask = m;
    bus.fill_time  = f;
    bus.mix_time   = mx;
    bus.drain_time = d;
  endtask

  // Full F=4, M=3, D=2 run; optionally pulses start with a new config during MIX.
  task automatic nominal_run(input string tg, input logic [7:0] m, input bit inject);
    drive_start(m, DEF_FILL_TIME, DEF_MIX_TIME, DEF_DRAIN_TIME);
    chk({tg, "_launch"}, '0);
    bus.start = 1'b0;
    phase({tg, "_fill"}, ev(m, 3'b000, 0, 0, 1, 0, 0, 0), 4);
    chk({tg, "_lvl0"}, ev(8'h00, 3'b001, 0, 0, 1, 0, 0, 0));
    if (inject) drive_start(8'h0F, 16'd0, 16'd0, 16'd0);
    chk({tg, "_lvl0"}, ev(8'h00, 3'b001, 0, 0, 1, 0, 0, 0));
    bus.start = 1'b0;
    chk({tg, "_lvl0"}, ev(8'h00, 3'b001, 0, 0, 1, 0, 0, 0));
    phase({tg, "_lvl1"}, ev(8'h00, 3'b010, 0, 0, 1, 0, 0, 0), 3);
    phase({tg, "_lvl2"}, ev(8'h00, 3'b100, 0, 0, 1, 0, 0, 0), 3);
    phase({tg, "_drain"}, ev(8'h00, 3'b000, 1, 0, 1, 0, 0, 0), 2);
    phase({tg, "_flush"}, ev(8'h00, 3'b000, 1, 1, 1, 0, 0, 0), 2);
    chk({tg, "_done"}, ev(8'h00, 3'b000, 0, 0, 1, 1, 0, 0));
    chk({tg, "_idle"}, '0);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.inlet_mask = '0;
    bus.fill_time  = '0;
    bus.mix_time   = '0;
    bus.drain_time = '0;

    // Reset state
    #2;
    sample("reset_state", '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("post_reset_idle", '0);

    // Nominal run
    nominal_run("nom", 8'hFF, 1'b0);

    // Zero durations: each phase one cycle
    drive_start(8'h3C, 16'd0, 16'd0, 16'd0);
    chk("zero_launch", '0);
    bus.start = 1'b0;
    chk("zero_fill",  ev(8'h3C, 3'b000, 0, 0, 1, 0, 0, 0));
    chk("zero_lvl0",  ev(8'h00, 3'b001, 0, 0, 1, 0, 0, 0));
    chk("zero_lvl1",  ev(8'h00, 3'b010, 0, 0, 1, 0, 0, 0));
    chk("zero_lvl2",  ev(8'h00, 3'b100, 0, 0, 1, 0, 0, 0));
    chk("zero_drain", ev(8'h00, 3'b000, 1, 0, 1, 0, 0, 0));
    chk("zero_flush", ev(8'h00, 3'b000, 1, 1, 1, 0, 0, 0));
    chk("zero_done",  ev(8'h00, 3'b000, 0, 0, 1, 1, 0, 0));
    chk("zero_idle",  '0);

    // Bad config: empty mask
    drive_start(8'h00, 16'd4, 16'd3, 16'd2);
    chk("cfg_err_pulse", ev(8'h00, 3'b000, 0, 0, 0, 0, 0, 1));
    bus.start = 1'b0;
    phase("cfg_err_idle", '0, 3);

    // Abort in the second cycle of level 1; abort held into FLUSH has no effect
    drive_start(8'hA5, 16'd1, 16'd3, 16'd5);
    chk("abt_launch", '0);
    bus.start = 1'b0;
    chk("abt_fill", ev(8'hA5, 3'b000, 0, 0, 1, 0, 0, 0));
    phase("abt_lvl0", ev(8'h00, 3'b001, 0, 0, 1, 0, 0, 0), 3);
    chk("abt_lvl1", ev(8'h00, 3'b010, 0, 0, 1, 0, 0, 0));
    bus.abort = 1'b1;
    chk("abt_lvl1", ev(8'h00, 3'b010, 0, 0, 1, 0, 0, 0));
    phase("abt_flush", ev(8'h00, 3'b000, 1, 1, 1, 0, 0, 0), 2);
    bus.abort = 1'b0;
    phase("abt_flush", ev(8'h00, 3'b000, 1, 1, 1, 0, 0, 0), 3);
    chk("abt_done", ev(8'h00, 3'b000, 0, 0, 1, 1, 1, 0));
    chk("abt_idle", '0);

    // Start while busy is ignored
    nominal_run("busy_start", 8'hFF, 1'b1);

    // Asynchronous reset in the middle of DRAIN
    drive_start(8'hFF, 16'd4, 16'd3, 16'd2);
    chk("rst_launch", '0);
    bus.start = 1'b0;
    phase("rst_fill", ev(8'hFF, 3'b000, 0, 0, 1, 0, 0, 0), 4);
    phase("rst_lvl0", ev(8'h00, 3'b001, 0, 0, 1, 0, 0, 0), 3);
    phase("rst_lvl1", ev(8'h00, 3'b010, 0, 0, 1, 0, 0, 0), 3);
    phase("rst_lvl2", ev(8'h00, 3'b100, 0, 0, 1, 0, 0, 0), 3);
    chk("rst_drain", ev(8'h00, 3'b000, 1, 0, 1, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1 sample("rst_immediate", '0);
    phase("rst_hold", '0, 2);
    #3 rst_n = 1'b1;
    phase("rst_no_done", '0, 3);
    nominal_run("post_rst", 8'hFF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mix_tree_sequencer.md
Name: mix_tree_sequencer

Overview:
- Clocked valve sequencer for a parametrised binary mixer tree: N_INLETS source chambers feed LEVELS rows of pairwise mixers that converge to one outlet.
- Runs one timed fill, level-by-level mix, drain and flush cycle per start request. All valve outputs are registered.
- Sits between the host control interface and the chip's valve driver bank.
- Successor to the fixed 8-chamber, hand-wired mixing netlists. Generalises inlet count and tree depth, and adds programmable timing, an inlet mask and abort.

Parameters:
- N_INLETS, 8, number of source inlet valves (leaf chambers); power of two, at least 2.
- LEVELS, 3, mixer tree depth; must equal log2(N_INLETS).
- CNT_W, 16, width of the phase timing fields and the internal countdown.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- abort  in  1  level; forces the FLUSH phase from any busy state.
- inlet_mask  in  N_INLETS  inlets to open during FILL; latched at start.
- fill_time  in  CNT_W  FILL duration in cycles; latched at start.
- mix_time  in  CNT_W  duration of each mixer level in cycles; latched at start.
- drain_time  in  CNT_W  duration of DRAIN and of FLUSH in cycles; latched at start.
- inlet_valve  out  N_INLETS  open inlet valves.
- level_valve  out  LEVELS  one-hot enable of the active mixer row.
- out_valve  out  1  outlet valve.
- flush_valve  out  1  wash-line valve.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- aborted  out  1  valid with done; 1 if the run was aborted.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, all outputs 0, counters and latched config cleared. Reset mid-run closes every valve immediately and does not pulse done.
- Effective duration of every phase is max(T,1); a programmed value of 0 gives 1 cycle.
- States and transitions:
  - IDLE: start=1 with inlet_mask!=0 latches all config, then FILL on the next cycle. start=1 with mask==0 pulses cfg_err the next cycle and stays in IDLE.
  - FILL: inlet_valve = latched mask for F cycles, then MIX with level index 0.
  - MIX: level_valve = one-hot(level) for M cycles per level. Level increments 0..LEVELS-1; after the last level, DRAIN.
  - DRAIN: out_valve=1 for D cycles, then FLUSH.
  - FLUSH: flush_valve=1 and out_valve=1 for D cycles, then DONE.
  - DONE: done=1 for one cycle, aborted per run flag, then IDLE. aborted clears in IDLE.
- Exactly one phase's valves are active in any cycle; there is no overlap between phases.
- Timing: start sampled at edge k gives outputs of the first FILL cycle after edge k+1. Total busy cycles = F + LEVELS*M + 2D + 1, including DONE.
- start while busy is ignored. Config inputs are don't-care outside the start cycle.
- abort=1 in FILL, MIX or DRAIN: next cycle enters FLUSH with a fresh D-cycle timer and sets the aborted flag.
- abort in FLUSH or DONE has no effect.
- start and abort together in IDLE: start wins; abort is evaluated from the next cycle.
- Countdown loads max(T,1)-1 on phase entry. The phase exits when the countdown reaches 0. Unsigned arithmetic, no wrap beyond the phase.

Decomposition:
- Shared package mfda_seq_pkg holds:
  - state enum {IDLE, FILL, MIX, DRAIN, FLUSH, DONE};
  - a helper that clamps duration 0 to 1;
  - default timing constants.
- Sub-module phase_timer(CNT_W): load/value/expire countdown, instantiated once.
- The FSM, level counter and valve decode stay in mix_tree_sequencer.

Test Plan:
- Nominal run: mask=8'hFF, F=4, M=3, D=2, LEVELS=3. Required: busy for 4+9+4+1=18 cycles; inlet_valve=FF for 4 cycles; level_valve sequence 001, 010, 100 for 3 cycles each; out_valve for 4 cycles; flush for 2; done with aborted=0.
- Zero times: F=M=D=0. Required: every phase lasts 1 cycle; busy for 1+3+2+1=7 cycles.
- Bad config: start with mask=0. Required: cfg_err pulses once, busy stays 0, no valve opens.
- Abort: abort raised in the 2nd cycle of level 1, D=5. Required: next cycle flush_valve=1 and out_valve=1 for 5 cycles, level_valve=0, then done=1 with aborted=1.
- Busy start: start pulsed during MIX with a new mask=8'h0F. Required: ignored; the run completes with the original timing.
- Async reset: rst_n low mid-DRAIN, asynchronous to clk. Required: all outputs 0 immediately and no done pulse; a start after release runs a full nominal cycle.
